// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data memory and its block-copy DMA.
// Holds the DMA state encoding, the byte stride between consecutive
// vector words, and the default memory geometry so that the DMA and
// the data memory agree on word and address widths.
// No ports (package).

package dmem_pkg;

    // Default memory geometry: words in the memory, elements per word,
    // and bits per element. A word is ELEM_SIZE*VECT_SIZE bits wide.
    localparam int DATA_SLOTS = 64;
    localparam int VECT_SIZE  = 8;
    localparam int ELEM_SIZE  = 8;

    // Byte distance between consecutive vector words.
    localparam int WORD_BYTES = 4;

    // Copy engine states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

endpackage

// File: rtl/dmem_dma.sv
// dmem_dma
// Block-copy initiator for the data memory. Copies len consecutive
// vector words from src_base to dst_base through the memory's single
// port, alternating one READ cycle and one WRITE cycle per word, in
// ascending address order. An external mux grants the port while busy.
//
// Optional feature macro: DMA_XOR_EN
//   defined   -> key port exists, key is latched at start and every
//                written word is the read word XOR key.
//   undefined -> plain copy, no key port.
//
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      synchronous active-high reset
//   start     in  1      copy request, only honoured in IDLE
//   src_base  in  W      byte address of the first source word
//   dst_base  in  W      byte address of the first destination word
//   len       in  LEN_W  number of words to copy (0..DATA_SLOTS)
//   key       in  W      XOR key (DMA_XOR_EN only)
//   busy      out 1      high in READ and WRITE
//   done      out 1      one-cycle completion pulse
//   mem_a     out W      memory byte address
//   mem_we    out 1      memory write enable
//   mem_wd    out W      memory write data
//   mem_rd    in  W      memory read data, combinational from mem_a

module dmem_dma #(
    parameter  int DATA_SLOTS = dmem_pkg::DATA_SLOTS,
    parameter  int VECT_SIZE  = dmem_pkg::VECT_SIZE,
    parameter  int ELEM_SIZE  = dmem_pkg::ELEM_SIZE,
    localparam int W          = ELEM_SIZE * VECT_SIZE,
    localparam int LEN_W      = $clog2(DATA_SLOTS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     src_base,
    input  logic [W-1:0]     dst_base,
    input  logic [LEN_W-1:0] len,
`ifdef DMA_XOR_EN
    input  logic [W-1:0]     key,
`endif
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     mem_a,
    output logic             mem_we,
    output logic [W-1:0]     mem_wd,
    input  logic [W-1:0]     mem_rd
);

    import dmem_pkg::*;

    localparam logic [W-1:0]     STRIDE  = W'(WORD_BYTES);
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    dma_state_t       state_q;
    logic [W-1:0]     src_q;
    logic [W-1:0]     dst_q;
    logic [LEN_W-1:0] cnt_q;

    // Registered copies of every output. buf_q is the word buffer and is
    // driven straight onto mem_wd; it is only non-zero during WRITE.
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     mem_a_q;
    logic             mem_we_q;
    logic [W-1:0]     buf_q;

    // Word captured during READ. With the XOR feature the key is folded in
    // at capture time, so the buffer already holds buf ^ key_q and mem_wd
    // stays a plain register with no path from mem_rd.
    logic [W-1:0]     buf_d;

`ifdef DMA_XOR_EN
    logic [W-1:0]     key_q;

    assign buf_d = mem_rd ^ key_q;
`else
    assign buf_d = mem_rd;
`endif

    // Single FSM block. Outputs are computed for the state being entered,
    // so that during each state the registered outputs already show that
    // state's bus cycle. Each branch starts from an all-quiet output set
    // and raises only what the next state needs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mem_a_q  <= '0;
            mem_we_q <= 1'b0;
            buf_q    <= '0;
`ifdef DMA_XOR_EN
            key_q    <= '0;
`endif
        end else begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mem_a_q  <= '0;
            mem_we_q <= 1'b0;
            buf_q    <= '0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q <= src_base;
                        dst_q <= dst_base;
                        cnt_q <= len;
`ifdef DMA_XOR_EN
                        key_q <= key;
`endif
                        if (len != '0) begin
                            state_q <= READ;
                            busy_q  <= 1'b1;
                            mem_a_q <= src_base;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                READ: begin
                    // Capture the source word and present the destination
                    // write for the coming WRITE cycle.
                    buf_q    <= buf_d;
                    src_q    <= src_q + STRIDE;
                    state_q  <= WRITE;
                    busy_q   <= 1'b1;
                    mem_a_q  <= dst_q;
                    mem_we_q <= 1'b1;
                end

                WRITE: begin
                    dst_q <= dst_q + STRIDE;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        // src_q was already advanced in READ, so it now
                        // points at the next source word.
                        state_q <= READ;
                        busy_q  <= 1'b1;
                        mem_a_q <= src_q;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign mem_a  = mem_a_q;
    assign mem_we = mem_we_q;
    assign mem_wd = buf_q;

endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma
// Directed bench for dmem_dma. A small word-addressed memory model sits
// on the DMA's port (combinational read, write on the rising edge) and
// has a private preload port used only while the DMA is idle.
// Build with DMA_XOR_EN defined to include the XOR copy vectors.
// Ports: none (top-level bench).

module tb_dmem_dma;

    localparam int W      = 64;
    localparam int SLOTS  = 64;
    localparam int SLOT_W = 6;
    localparam int LEN_W  = 7;

    logic             clk;
    logic             reset;
    logic             start;
    logic [W-1:0]     src_base;
    logic [W-1:0]     dst_base;
    logic [LEN_W-1:0] len;
`ifdef DMA_XOR_EN
    logic [W-1:0]     key;
`endif
    logic             busy;
    logic             done;
    logic [W-1:0]     mem_a;
    logic             mem_we;
    logic [W-1:0]     mem_wd;
    logic [W-1:0]     mem_rd;

    logic [W-1:0]     mem [0:SLOTS-1];
    logic [W-1:0]     snap [0:SLOTS-1];
    logic             tbWe;
    logic [SLOT_W-1:0] tbIdx;
    logic [W-1:0]     tbData;

    logic [31:0]      busyBits;
    logic [31:0]      doneBits;
    logic [31:0]      weBits;
    logic [W-1:0]     aLog  [0:31];
    logic [W-1:0]     wdLog [0:31];

    int checks;
    int failures;

    dmem_dma dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .len      (len),
`ifdef DMA_XOR_EN
        .key      (key),
`endif
        .busy     (busy),
        .done     (done),
        .mem_a    (mem_a),
        .mem_we   (mem_we),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: slot index is the word part of the byte address,
    // taken modulo the number of slots.
    assign mem_rd = mem[mem_a[2 +: SLOT_W]];

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_a[2 +: SLOT_W]] <= mem_wd;
        else if (tbWe)
            mem[tbIdx] <= tbData;
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Writes one memory word through the preload port.
    task automatic writeWord(input int idx, input logic [W-1:0] data);
        @(negedge clk);
        tbWe   = 1'b1;
        tbIdx  = SLOT_W'(idx);
        tbData = data;
        @(negedge clk);
        tbWe   = 1'b0;
    endtask

    // Pulses start in cycle 0 and logs the outputs of cycles 1..nCycles.
    // A second start with different operands can be raised during cycle
    // pulseAt, and reset during cycle resetAt (both take effect at the
    // edge that ends that cycle). 0 disables either.
    task automatic applyStimulus(input logic [W-1:0] srcIn, input logic [W-1:0] dstIn,
                                 input int lenIn, input logic [W-1:0] keyIn,
                                 input int pulseAt, input int resetAt, input int nCycles);
        busyBits = '0;
        doneBits = '0;
        weBits   = '0;
        @(negedge clk);
        src_base = srcIn;
        dst_base = dstIn;
        len      = LEN_W'(lenIn);
`ifdef DMA_XOR_EN
        key      = keyIn;
`else
        if (keyIn != '0) $display("[TB] note: key ignored without DMA_XOR_EN");
`endif
        start    = 1'b1;
        for (int c = 1; c <= nCycles; c++) begin
            @(negedge clk);
            busyBits[c] = busy;
            doneBits[c] = done;
            weBits[c]   = mem_we;
            aLog[c]     = mem_a;
            wdLog[c]    = mem_wd;
            start = (c == pulseAt);
            reset = (c == resetAt);
            if (c == pulseAt) begin
                src_base = 64'h100;
                dst_base = 64'h000;
                len      = LEN_W'(2);
`ifdef DMA_XOR_EN
                key      = 64'h5555_5555_5555_5555;
`endif
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int changed;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        src_base = '0;
        dst_base = '0;
        len      = '0;
`ifdef DMA_XOR_EN
        key      = '0;
`endif
        tbWe     = 1'b0;
        tbIdx    = '0;
        tbData   = '0;

        // Reset and check the idle outputs.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy",   W'(busy),   '0);
        checkOutput("rst_done",   W'(done),   '0);
        checkOutput("rst_we",     W'(mem_we), '0);
        checkOutput("rst_a",      mem_a,      '0);
        checkOutput("rst_wd",     mem_wd,     '0);

        // Clear memory and load the first source block.
        for (int i = 0; i < SLOTS; i++) writeWord(i, '0);
        writeWord(0, 64'h11);
        writeWord(1, 64'h22);
        writeWord(2, 64'h33);
        writeWord(3, 64'h44);

        // Basic copy of 4 words from 0x00 to 0x40.
        applyStimulus(64'h00, 64'h40, 4, '0, 0, 0, 12);
        checkOutput("t1_busy_cycles", W'(busyBits), 64'h01FE);
        checkOutput("t1_done_cycles", W'(doneBits), 64'h0200);
        checkOutput("t1_we_cycles",   W'(weBits),   64'h0154);
        checkOutput("t1_a_c1",  aLog[1],  64'h00);
        checkOutput("t1_a_c2",  aLog[2],  64'h40);
        checkOutput("t1_wd_c2", wdLog[2], 64'h11);
        checkOutput("t1_a_c3",  aLog[3],  64'h04);
        checkOutput("t1_w16", mem[16], 64'h11);
        checkOutput("t1_w17", mem[17], 64'h22);
        checkOutput("t1_w18", mem[18], 64'h33);
        checkOutput("t1_w19", mem[19], 64'h44);

        // Zero-length request: done in cycle 1, no memory traffic.
        for (int i = 0; i < SLOTS; i++) snap[i] = mem[i];
        applyStimulus(64'h00, 64'h40, 0, '0, 0, 0, 6);
        checkOutput("t2_done_cycles", W'(doneBits), 64'h0002);
        checkOutput("t2_we_cycles",   W'(weBits),   '0);
        checkOutput("t2_busy_cycles", W'(busyBits), '0);
        changed = 0;
        for (int i = 0; i < SLOTS; i++) if (mem[i] !== snap[i]) changed++;
        checkOutput("t2_mem_changed", W'(changed), '0);

        // Second start during cycle 3 must be ignored.
        applyStimulus(64'h00, 64'h80, 4, '0, 3, 0, 12);
        checkOutput("t3_done_cycles", W'(doneBits), 64'h0200);
        checkOutput("t3_busy_cycles", W'(busyBits), 64'h01FE);
        checkOutput("t3_a_c5", aLog[5], 64'h08);
        checkOutput("t3_a_c6", aLog[6], 64'h88);
        checkOutput("t3_w32", mem[32], 64'h11);
        checkOutput("t3_w33", mem[33], 64'h22);
        checkOutput("t3_w34", mem[34], 64'h33);
        checkOutput("t3_w35", mem[35], 64'h44);
        checkOutput("t3_w0_kept", mem[0], 64'h11);

        // Reset lands at the edge that would start cycle 4 of a len=8 copy:
        // word 0 is written in cycle 2, word 1 is never written.
        applyStimulus(64'h00, 64'hC0, 8, '0, 0, 3, 8);
        checkOutput("t4_busy_cycles", W'(busyBits), 64'h000E);
        checkOutput("t4_we_cycles",   W'(weBits),   64'h0004);
        checkOutput("t4_done_cycles", W'(doneBits), '0);
        checkOutput("t4_a_c4", aLog[4], '0);
        checkOutput("t4_w48", mem[48], 64'h11);
        checkOutput("t4_w49", mem[49], '0);

        // A copy after the reset runs normally.
        applyStimulus(64'h08, 64'hC4, 2, '0, 0, 0, 8);
        checkOutput("t4b_done_cycles", W'(doneBits), 64'h0020);
        checkOutput("t4b_w49", mem[49], 64'h33);
        checkOutput("t4b_w50", mem[50], 64'h44);

        // Overlapping forward copy smears word 0 across words 0..3.
        writeWord(0, 64'hA);
        writeWord(1, 64'hB);
        writeWord(2, 64'hC);
        writeWord(3, 64'hD);
        applyStimulus(64'h00, 64'h04, 3, '0, 0, 0, 9);
        checkOutput("t5_done_cycles", W'(doneBits), 64'h0080);
        checkOutput("t5_w0", mem[0], 64'hA);
        checkOutput("t5_w1", mem[1], 64'hA);
        checkOutput("t5_w2", mem[2], 64'hA);
        checkOutput("t5_w3", mem[3], 64'hA);

`ifdef DMA_XOR_EN
        // XOR copy with an all-ones key, then copy back with the same key.
        writeWord(4, 64'h0);
        writeWord(5, 64'h0F0F_0F0F_0F0F_0F0F);
        applyStimulus(64'h10, 64'h60, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 8);
        checkOutput("x_w24", mem[24], 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("x_w25", mem[25], 64'hF0F0_F0F0_F0F0_F0F0);
        writeWord(4, 64'h1234);
        writeWord(5, 64'h5678);
        applyStimulus(64'h60, 64'h10, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 8);
        checkOutput("x_back_w4", mem[4], 64'h0);
        checkOutput("x_back_w5", mem[5], 64'h0F0F_0F0F_0F0F_0F0F);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
